// File: rtl/cc_event_capture.sv
// rtl/cc_event_capture.sv - change detector on a sampled control word with a time-stamped FWFT event FIFO
module cc_event_capture #(
  parameter int WIDTH  = 20,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 12,
  parameter int DROP_W = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_vec,
  input  logic                     sample_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_vec,
  output logic [TS_W-1:0]          out_ts,
  output logic                     out_first,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem_vec [DEPTH];
  logic [TS_W-1:0]   r_mem_ts  [DEPTH];
  logic [DEPTH-1:0]  r_mem_first;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic [TS_W-1:0]   r_ts;
  logic [WIDTH-1:0]  r_ref_vec;
  logic              r_have_ref;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  logic w_event;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  assign w_event = sample_en & (~r_have_ref | (in_vec != r_ref_vec));
  assign w_pop   = (r_level != '0) & out_ready;
  assign w_full  = (r_level == FULL_LVL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & ~w_push;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_vec[i] <= '0;
        r_mem_ts[i]  <= '0;
      end
      r_mem_first  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ts         <= '0;
      r_ref_vec    <= '0;
      r_have_ref   <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;

      if (w_event) begin
        r_ref_vec  <= in_vec;
        r_have_ref <= 1'b1;
      end

      if (w_push) begin
        r_mem_vec[r_wr_ptr]   <= in_vec;
        r_mem_ts[r_wr_ptr]    <= r_ts;
        r_mem_first[r_wr_ptr] <= ~r_have_ref;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // A drop coinciding with clear_ovf counts as the first drop after the clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clear_ovf) begin
          r_drop_count <= DROP_W'(1);
        end else if (!(&r_drop_count)) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
      end else if (clear_ovf) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end
    end
  end

  assign out_valid  = (r_level != '0);
  assign out_vec    = r_mem_vec[r_rd_ptr];
  assign out_ts     = r_mem_ts[r_rd_ptr];
  assign out_first  = r_mem_first[r_rd_ptr];
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_cc_event_capture.sv
// tb/tb_cc_event_capture.sv - table, directed and random checks of cc_event_capture against a queue model
module tb_cc_event_capture;

  localparam int W  = 20;
  localparam int D  = 8;
  localparam int TW = 12;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  in_vec = '0;
  logic          sample_en = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_vec;
  logic [TW-1:0] out_ts;
  logic          out_first;
  logic [3:0]    level;
  logic          overflow;
  logic [DW-1:0] drop_count;

  cc_event_capture #(.WIDTH(W), .DEPTH(D), .TS_W(TW), .DROP_W(DW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_vec     (in_vec),
    .sample_en  (sample_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_ts     (out_ts),
    .out_first  (out_first),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clear_ovf  (clear_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] vec;
    int           ts;
    bit           first;
  } ev_t;

  typedef struct {
    bit           en;
    logic [W-1:0] vec;
    bit           rdy;
    int           exp_level;
    logic [W-1:0] exp_vec;
    int           exp_ts;
    bit           exp_first;
    bit           exp_ovf;
    int           exp_drop;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ev_t          m_q[$];
  logic [W-1:0] m_ref  = '0;
  bit           m_have = 1'b0;
  int           m_ts   = 0;
  bit           m_ovf  = 1'b0;
  int           m_drop = 0;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Applies the rules for one rising edge to the abstract event queue.
  task automatic model_edge();
    bit  full;
    bit  pop;
    bit  ev;
    bit  dropped;
    ev_t e;
    if (!reset_n) begin
      m_q.delete();
      m_ref  = '0;
      m_have = 1'b0;
      m_ts   = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
      return;
    end
    full    = (m_q.size() == D);
    pop     = (m_q.size() > 0) && out_ready;
    ev      = sample_en && (!m_have || (in_vec != m_ref));
    dropped = 1'b0;
    e.vec   = in_vec;
    e.ts    = m_ts;
    e.first = !m_have;
    if (ev) begin
      m_ref  = in_vec;
      m_have = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      if (!full || pop) m_q.push_back(e);
      else dropped = 1'b1;
    end
    if (dropped) begin
      m_ovf  = 1'b1;
      m_drop = clear_ovf ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clear_ovf) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    m_ts = (m_ts + 1) % 4096;
  endtask

  task automatic model_check();
    chk("m_valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("m_level", 32'(level), 32'(m_q.size()));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_drop_count", 32'(drop_count), 32'(m_drop));
    if (m_q.size() > 0) begin
      chk("m_out_vec", 32'(out_vec), 32'(m_q[0].vec));
      chk("m_out_ts", 32'(out_ts), 32'(m_q[0].ts));
      chk("m_out_first", 32'(out_first), 32'(m_q[0].first));
    end
  endtask

  task automatic step(input bit rn, input bit en, input logic [W-1:0] v, input bit rdy, input bit clr);
    reset_n   = rn;
    sample_en = en;
    in_vec    = v;
    out_ready = rdy;
    clear_ovf = clr;
    @(posedge clock);
    model_edge();
    #1;
    model_check();
    cyc++;
  endtask

  function automatic vec_t mk(bit en, int vec, bit rdy, int lvl, int evec, int ets,
                              bit efirst, bit eovf, int edrop);
    vec_t r;
    r.en = en; r.vec = W'(vec); r.rdy = rdy; r.exp_level = lvl;
    r.exp_vec = W'(evec); r.exp_ts = ets; r.exp_first = efirst;
    r.exp_ovf = eovf; r.exp_drop = edrop;
    return r;
  endfunction

  initial begin
    // Single held value yields one event; then ten changes overflow an 8-deep FIFO and drain in order.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 'h10, 1, (i == 0) ? 1 : 0, 'h10, 0, 1, 0, 0));
    for (int i = 1; i <= 10; i++)
      tbl.push_back(mk(1, i, 0, (i > 8) ? 8 : i, 1, 5, 0, i > 8, (i > 8) ? i - 8 : 0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 0, 1, 8 - k, k + 1, 5 + k, 0, 1, 2));

    step(0, 0, '0, 0, 0);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_drop", 32'(drop_count), 0);
    chk("reset_vec", 32'(out_vec), 0);

    foreach (tbl[i]) begin
      step(1, tbl[i].en, tbl[i].vec, tbl[i].rdy, 0);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_level > 0));
      chk("tbl_level", 32'(level), 32'(tbl[i].exp_level));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
      chk("tbl_drop", 32'(drop_count), 32'(tbl[i].exp_drop));
      if (tbl[i].exp_level > 0) begin
        chk("tbl_vec", 32'(out_vec), 32'(tbl[i].exp_vec));
        chk("tbl_ts", 32'(out_ts), 32'(tbl[i].exp_ts));
        chk("tbl_first", 32'(out_first), 32'(tbl[i].exp_first));
      end
    end

    // Full FIFO with a pop and a new change in the same cycle.
    step(0, 0, '0, 0, 0);
    for (int i = 1; i <= 8; i++) step(1, 1, W'(i), 0, 0);
    step(1, 1, W'('h99), 1, 0);
    chk("full_pushpop_level", 32'(level), 8);
    chk("full_pushpop_ovf", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) step(1, 0, '0, 1, 0);
    chk("full_pushpop_last_vec", 32'(out_vec), 'h99);
    chk("full_pushpop_last_level", 32'(level), 1);
    step(1, 0, '0, 1, 0);
    chk("full_pushpop_empty", 32'(level), 0);

    // Drop coinciding with clear_ovf.
    step(0, 0, '0, 0, 0);
    for (int i = 1; i <= 13; i++) step(1, 1, W'('h100 + i), 0, 0);
    chk("drop5", 32'(drop_count), 5);
    step(1, 1, W'('hAB), 0, 1);
    chk("clr_drop_ovf", 32'(overflow), 1);
    chk("clr_drop_cnt", 32'(drop_count), 1);
    step(1, 0, '0, 0, 1);
    chk("clr_only_ovf", 32'(overflow), 0);
    chk("clr_only_cnt", 32'(drop_count), 0);

    // Timestamp wrap across a long idle gap.
    step(0, 0, '0, 0, 0);
    step(1, 1, W'('h5), 1, 0);
    chk("wrap_t0", 32'(out_ts), 0);
    for (int i = 0; i < 4100; i++) step(1, 0, W'('h5), 1, 0);
    step(1, 1, W'('h6), 1, 0);
    chk("wrap_ts", 32'(out_ts), 32'((0 + 4101) % 4096));

    // Reset with three queued events, then an unchanged sample.
    step(0, 0, '0, 0, 0);
    step(1, 1, W'('h7), 0, 0);
    step(1, 1, W'('h8), 0, 0);
    step(1, 1, W'('h9), 0, 0);
    chk("pre_reset_level", 32'(level), 3);
    step(0, 1, W'('h9), 0, 0);
    chk("mid_reset_valid", 32'(out_valid), 0);
    chk("mid_reset_level", 32'(level), 0);
    step(1, 1, W'('h9), 0, 0);
    chk("post_reset_valid", 32'(out_valid), 1);
    chk("post_reset_first", 32'(out_first), 1);
    chk("post_reset_vec", 32'(out_vec), 'h9);

    // Random traffic with occasional clears and resets.
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) != 0),
           W'($urandom_range(0, 3)) * W'('h11111),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
